// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte FIFO that feeds a UART transmitter one byte at a time. Bytes are
// written with i_Wr_En/i_Wr_Byte, stored in a circular buffer, and launched
// with a one-cycle o_TX_DV strobe. The next launch waits until the
// transmitter reports completion on i_TX_Done.
//
// Handshake: a write is taken on any rising edge where i_Wr_En=1 and the
// FIFO has room (either not full, or a launch pop happens on the same edge);
// otherwise the byte is dropped. o_TX_DV is a single-cycle strobe, and
// o_TX_Byte stays stable until the next strobe. i_TX_Done is only honoured
// while o_Busy=1.
//
// DEPTH must be a power of two and at least 2, so pointers wrap by overflow.
//
// Optional build macro: UART_TX_FEEDER_OVF_FLAG_EN adds a sticky o_Overflow
// output that records the first dropped write until reset.

module uart_tx_feeder #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_Wr_En,
    input  logic [7:0]    i_Wr_Byte,
    input  logic          i_TX_Done,
    output logic          o_TX_DV,
    output logic [7:0]    o_TX_Byte,
    output logic          o_Full,
    output logic          o_Empty,
    output logic [AW:0]   o_Count,
    output logic          o_Busy
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    ,
    output logic          o_Overflow
`endif
);

    // Launcher states: IDLE may launch the head byte, WAIT_DONE waits for
    // the transmitter's completion pulse. The state is visible on o_Busy.
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_STEP = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_STEP   = AW'(1);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          push;

    // Status flags come only from the registered count, never from i_Wr_En.
    assign o_Count = count;
    assign o_Full  = (count == COUNT_FULL);
    assign o_Empty = (count == '0);
    assign o_Busy  = (state == WAIT_DONE);

    // A launch pops the head; a pop frees a slot on the same edge, so a
    // write into a full FIFO is accepted when it coincides with a launch.
    assign pop  = (state == IDLE) && !o_Empty;
    assign push = i_Wr_En && (!o_Full || pop);

    // Byte storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    // Read and write pointers; they wrap naturally at DEPTH.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_STEP;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + COUNT_STEP;
                2'b01:   count <= count - COUNT_STEP;
                default: count <= count;
            endcase
        end
    end

    // Launcher FSM with registered strobe and byte outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
        end else begin
            o_TX_DV <= 1'b0;
            case (state)
                IDLE: begin
                    // i_TX_Done is ignored here; only a non-empty FIFO matters.
                    if (!o_Empty) begin
                        o_TX_Byte <= mem[rd_ptr];
                        o_TX_DV   <= 1'b1;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Returning through IDLE guarantees a gap of at least one
                    // cycle between completion and the next launch.
                    if (i_TX_Done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    // Sticky record of any write that found no room.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Overflow <= 1'b0;
        end else if (i_Wr_En && !push) begin
            o_Overflow <= 1'b1;
        end
    end
`else
    // Dropped writes leave no trace in this build.
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: queue-based reference model, per-cycle
// compare process, a transmitter responder, and directed plus random phases.

module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    // ---------------- clock / reset ----------------
    logic          clk     = 1'b0;
    logic          rst_l   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [7:0]    wr_byte = 8'h00;
    logic          tx_done = 1'b0;
    logic          o_tx_dv;
    logic [7:0]    o_tx_byte;
    logic          o_full;
    logic          o_empty;
    logic [AW:0]   o_count;
    logic          o_busy;
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    logic          o_ovf;
`endif

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .i_Clock   (clk),
        .i_Rst_L   (rst_l),
        .i_Wr_En   (wr_en),
        .i_Wr_Byte (wr_byte),
        .i_TX_Done (tx_done),
        .o_TX_DV   (o_tx_dv),
        .o_TX_Byte (o_tx_byte),
        .o_Full    (o_full),
        .o_Empty   (o_empty),
        .o_Count   (o_count),
        .o_Busy    (o_busy)
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        ,
        .o_Overflow(o_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- reference model ----------------
    // The FIFO is a queue of accepted bytes; the transmitter link is a busy
    // flag. Each edge: a completion frees the link, an idle link takes the
    // head, then a write is accepted if the queue has room after that pop.
    logic [7:0] exp_q[$];
    bit         m_busy = 0;
    bit         m_dv   = 0;
    bit         m_ovf  = 0;
    logic [7:0] m_byte = 8'h00;

    initial begin
        forever begin
            @(posedge clk or negedge rst_l);
            if (!rst_l) begin
                exp_q.delete();
                m_busy = 0;
                m_dv   = 0;
                m_ovf  = 0;
                m_byte = 8'h00;
            end else begin
                bit launch;
                launch = !m_busy && (exp_q.size() > 0);
                m_dv = 0;
                if (m_busy && tx_done) m_busy = 0;
                if (launch) begin
                    m_byte = exp_q.pop_front();
                    m_dv   = 1;
                    m_busy = 1;
                end
                if (wr_en) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(wr_byte);
                    else                      m_ovf = 1;
                end
            end
        end
    end

    // ---------------- compare process + output log ----------------
    logic [7:0] out_log[$];
    int         gap_log[$];
    int         launch_cyc[$];
    int         last_done_cycle = -100;

    initial begin
        forever begin
            @(negedge clk);
            check("tx_dv",   o_tx_dv,   m_dv);
            check("tx_byte", o_tx_byte, m_byte);
            check("busy",    o_busy,    m_busy);
            check("count",   o_count,   exp_q.size());
            check("full",    o_full,    exp_q.size() == DEPTH);
            check("empty",   o_empty,   exp_q.size() == 0);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
            check("overflow", o_ovf, m_ovf);
`endif
            if (o_tx_dv) begin
                out_log.push_back(o_tx_byte);
                gap_log.push_back(cycle - last_done_cycle);
                launch_cyc.push_back(cycle);
            end
        end
    end

    // ---------------- transmitter responder ----------------
    bit resp_en    = 1;
    bit rand_delay = 0;
    bit spurious   = 0;
    int resp_delay = 10;
    bit resp_wait  = 0;
    int resp_cnt   = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!rst_l) begin
                resp_wait = 0;
            end else if (resp_wait) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    tx_done = 1'b1;
                    last_done_cycle = cycle;
                    resp_wait = 0;
                end
            end else if (o_tx_dv && resp_en) begin
                int d;
                d = rand_delay ? int'($urandom_range(0, 6)) : resp_delay;
                if (d == 0) begin
                    tx_done = 1'b1;
                    last_done_cycle = cycle;
                end else begin
                    resp_wait = 1;
                    resp_cnt  = d;
                end
            end else if (spurious && !o_busy && $urandom_range(0, 7) == 0) begin
                tx_done = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            wr_en   = 1'b1;
            wr_byte = base + 8'(i);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n;
        n = 0;
        while (!(o_empty && !o_busy) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, (o_empty && !o_busy), 1);
    endtask

    task automatic manual_done();
        @(posedge clk);
        #2;
        tx_done = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [7:0] wr_log[$];
    int         w_cyc;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_dv",    o_tx_dv,   0);
        check("rst_byte",  o_tx_byte, 8'h00);
        check("rst_count", o_count,   0);
        check("rst_empty", o_empty,   1);
        check("rst_full",  o_full,    0);
        check("rst_busy",  o_busy,    0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(posedge clk);

        // Single byte: write at cycle 0, launch visible at cycle 2
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_byte = 8'hA5; w_cyc = cycle;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("a5_c1_count", o_count, 1);
        check("a5_c1_dv",    o_tx_dv, 0);
        @(posedge clk);
        #1;
        check("a5_dv",      o_tx_dv,   1);
        check("a5_byte",    o_tx_byte, 8'hA5);
        check("a5_busy",    o_busy,    1);
        check("a5_count",   o_count,   0);
        check("a5_latency", cycle - w_cyc, 2);
        wait_drain(100, "a5_drain");

        // Three bytes, completion 10 cycles after each launch
        out_log.delete(); gap_log.delete(); launch_cyc.delete();
        @(posedge clk);
        #1;
        w_cyc = cycle + 1;
        write_seq(8'h01, 3);
        wait_drain(200, "seq3_drain");
        check("seq3_len", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("seq3_b0", out_log[0], 8'h01);
            check("seq3_b1", out_log[1], 8'h02);
            check("seq3_b2", out_log[2], 8'h03);
            check("seq3_first_lat", launch_cyc[0] - w_cyc, 2);
            check("seq3_gap1", gap_log[1], 2);
            check("seq3_gap2", gap_log[2], 2);
        end

        // Random traffic, 40 bytes, occupancy kept below DEPTH
        rand_delay = 1; spurious = 1;
        out_log.delete(); wr_log.delete();
        begin
            int n_wr;
            int guard;
            n_wr = 0; guard = 0;
            while (n_wr < 40 && guard < 3000) begin
                @(posedge clk);
                #1;
                guard++;
                if (exp_q.size() < 15 && $urandom_range(0, 2) != 0) begin
                    wr_en   = 1'b1;
                    wr_byte = 8'($urandom);
                    wr_log.push_back(wr_byte);
                    n_wr++;
                end else begin
                    wr_en = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            check("rand_nwr", n_wr, 40);
        end
        wait_drain(500, "rand_drain");
        rand_delay = 0; spurious = 0;
        check("rand_len", out_log.size(), wr_log.size());
        for (int i = 0; i < wr_log.size() && i < out_log.size(); i++) begin
            check("rand_order", out_log[i], wr_log[i]);
        end

        // Overflow: 18 writes with the transmitter stalled
        resp_en = 0;
        out_log.delete();
        write_seq(8'h00, 18);
        check("ovf_count", o_count,   16);
        check("ovf_full",  o_full,    1);
        check("ovf_busy",  o_busy,    1);
        check("ovf_head",  o_tx_byte, 8'h00);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        check("ovf_flag", o_ovf, 1);
`endif
        manual_done();
        resp_en = 1;
        wait_drain(400, "ovf_drain");
        check("ovf_len", out_log.size(), 17);
        for (int i = 1; i < out_log.size() && i < 17; i++) begin
            check("ovf_order", out_log[i], 8'(i));
        end
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        check("ovf_sticky", o_ovf, 1);
`endif

        // Full FIFO: write coincident with a launch pop
        resp_en = 0;
        out_log.delete();
        write_seq(8'h20, 17);
        check("fullpop_pre_count", o_count, 16);
        manual_done();
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_byte = 8'hEE; resp_en = 1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("fullpop_count", o_count,   16);
        check("fullpop_dv",    o_tx_dv,   1);
        check("fullpop_byte",  o_tx_byte, 8'h21);
        wait_drain(400, "fullpop_drain");
        check("fullpop_len", out_log.size(), 18);
        if (out_log.size() == 18) begin
            check("fullpop_last", out_log[17], 8'hEE);
        end

        // Asynchronous reset while waiting with 5 bytes queued
        resp_en = 0;
        write_seq(8'h40, 6);
        check("rstmid_count", o_count, 5);
        check("rstmid_busy",  o_busy,  1);
        #2;
        rst_l = 1'b0;
        #1;
        check("rstmid_dv",    o_tx_dv,   0);
        check("rstmid_byte",  o_tx_byte, 8'h00);
        check("rstmid_cnt0",  o_count,   0);
        check("rstmid_empty", o_empty,   1);
        check("rstmid_full",  o_full,    0);
        check("rstmid_busy0", o_busy,    0);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        check("rstmid_ovf", o_ovf, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        resp_en = 1;
        out_log.delete();
        repeat (8) @(posedge clk);
        #1;
        check("rstmid_quiet", out_log.size(), 0);
        write_seq(8'h77, 1);
        wait_drain(100, "rstmid_drain");
        check("rstmid_new_len", out_log.size(), 1);
        if (out_log.size() == 1) begin
            check("rstmid_new_byte", out_log[0], 8'h77);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO capacity in bytes; it must be a power of two and at least 2.
REQ-002 SHALL have localparam AW = $clog2(DEPTH), the FIFO pointer width.
REQ-003 SHALL have port i_Clock, input, 1 bit: system clock, rising edge.
REQ-004 SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_Wr_En, input, 1 bit: write strobe, one byte per cycle.
REQ-006 SHALL have port i_Wr_Byte, input, 8 bits: byte to enqueue.
REQ-007 SHALL have port i_TX_Done, input, 1 bit: one-cycle completion pulse from the serial transmitter.
REQ-008 SHALL have port o_TX_DV, output, 1 bit: one-cycle launch strobe to the transmitter.
REQ-009 SHALL have port o_TX_Byte, output, 8 bits: byte to the transmitter, valid while o_TX_DV=1.
REQ-010 SHALL have port o_Full, output, 1 bit: FIFO full, count == DEPTH.
REQ-011 SHALL have port o_Empty, output, 1 bit: FIFO empty, count == 0.
REQ-012 SHALL have port o_Count, output, AW+1 bits: bytes currently stored.
REQ-013 SHALL have port o_Busy, output, 1 bit: a byte is launched and its i_TX_Done is not yet seen.

Function
REQ-014 SHALL store bytes in a circular FIFO with AW-bit read and write pointers; pointers wrap from DEPTH-1 to 0.
REQ-015 SHALL enqueue i_Wr_Byte on a cycle with i_Wr_En=1 and o_Full=0.
REQ-016 SHALL silently drop the byte on a cycle with i_Wr_En=1 and o_Full=1, leaving FIFO contents and pointers unchanged.
REQ-017 SHALL derive o_Full, o_Empty and o_Count from registered state only, with no combinational path from i_Wr_En.
REQ-018 SHALL implement a two-state FSM: IDLE and WAIT_DONE.
REQ-019 IDLE with o_Empty=0 SHALL, on that cycle:
- register the head byte into o_TX_Byte;
- assert o_TX_DV for exactly one cycle (at the next edge);
- pop the FIFO;
- go to WAIT_DONE.
REQ-020 IDLE with o_Empty=1 SHALL remain in IDLE with o_TX_DV=0.
REQ-021 WAIT_DONE SHALL hold o_TX_Byte stable, keep o_TX_DV=0, and return to IDLE on the cycle after i_TX_Done=1.
REQ-022 SHALL ignore i_TX_Done while in IDLE.
REQ-023 SHALL space launches at least one cycle after i_TX_Done, so the transmitter is back in IDLE when o_TX_DV arrives.
REQ-024 SHALL assert o_Busy in WAIT_DONE and deassert it in IDLE.
REQ-025 On a simultaneous write and pop with the FIFO full, SHALL accept the write; o_Count stays DEPTH.
REQ-026 On a simultaneous write and pop with the FIFO not full, SHALL leave o_Count unchanged.
REQ-027 SHALL accept a write into an empty FIFO on the same cycle that IDLE sees o_Empty=1; that byte launches on the following cycle (first-write-to-o_TX_DV latency = 2 cycles).
REQ-028 SHALL drive out bytes in strict write order.

Reset
REQ-029 While i_Rst_L=0, SHALL asynchronously force:
- FSM to IDLE and both pointers to 0;
- o_Count=0, o_Empty=1, o_Full=0;
- o_TX_DV=0, o_TX_Byte=8'h00, o_Busy=0.
REQ-030 Reset mid-transfer SHALL discard all queued bytes and any pending i_TX_Done wait; FIFO storage itself need not be cleared.

Configuration
REQ-031 With macro UART_TX_FEEDER_OVF_FLAG_EN defined, SHALL add output port o_Overflow, 1 bit:
- sticky, set on the first dropped write (REQ-016);
- cleared only by reset.
REQ-032 Without UART_TX_FEEDER_OVF_FLAG_EN, SHALL have no o_Overflow port and no associated register; drop behaviour is unchanged.

Verification
REQ-033 Reset release, write 8'hA5 at cycle 0 -> o_TX_DV=1 with o_TX_Byte=8'hA5 at cycle 2, o_Busy=1 from cycle 2, o_Count back to 0.
REQ-034 Write 8'h01,8'h02,8'h03 back-to-back, pulse i_TX_Done 10 cycles after each launch -> three o_TX_DV pulses carrying 01,02,03 in order, each launch 2 cycles after the preceding i_TX_Done pulse.
REQ-035 DEPTH=16, i_TX_Done held 0 -> write 18 bytes 8'h00..8'h11; one byte pops, 16 are stored (o_Full=1), byte 8'h11 is dropped; with OVF macro, o_Overflow=1 and stays 1.
REQ-036 Write 40 bytes over time, keeping o_Count < 16, with Done responses -> pointers wrap twice, output sequence identical to input sequence.
REQ-037 Full FIFO, write coincident with a launch pop -> write accepted, o_Count stays 16, new byte emerges last.
REQ-038 Assert i_Rst_L=0 asynchronously while in WAIT_DONE with 5 bytes queued -> outputs at reset values immediately; after release, o_TX_DV stays 0 until a new write.
